// File: rtl/ifid_queue.sv
// IF/ID pipeline register built as a DEPTH-entry in-order queue of {pc, inst, pred}.
// Fetch pushes and decode pops, each with a valid/ready handshake; flush empties the queue.
module ifid_queue #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 32,
    parameter int unsigned DEPTH = 4,
    parameter logic [ILEN-1:0] NOP_INST = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [ILEN-1:0]            in_inst,
    input  logic                       in_pred,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [ILEN-1:0]            out_inst,
    output logic                       out_pred,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [ILEN-1:0] inst_mem_q [DEPTH];
    logic            pred_mem_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;

    // Handshake readiness comes only from registered occupancy, never from out_ready.
    assign in_ready  = (count_q != Full);
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        out_pc   = '0;
        out_inst = NOP_INST;
        out_pred = 1'b0;
        if (out_valid) begin
            out_pc   = pc_mem_q[rd_ptr_q];
            out_inst = inst_mem_q[rd_ptr_q];
            out_pred = pred_mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately unreset; it is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem_q[wr_ptr_q]   <= in_pc;
            inst_mem_q[wr_ptr_q] <= in_inst;
            pred_mem_q[wr_ptr_q] <= in_pred;
        end
    end

endmodule

// File: tb/tb_ifid_queue.sv
// Directed bench for ifid_queue: a scoreboard queue of pushed entries is compared
// against the head outputs every cycle, plus explicit checks at the key boundary points.
module tb_ifid_queue;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        pred;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        in_pred = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_pred;
    logic [2:0]  count;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ifid_queue #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .NOP_INST(NOP)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_pred(in_pred),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_pred(out_pred),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compares every output against the scoreboard model.
    task automatic check_model(input string tag);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(sb.size() != DEPTH));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(sb.size() != 0));
        chk({tag, ".count"}, 64'(count), 64'(sb.size()));
        if (sb.size() != 0) begin
            chk({tag, ".out_pc"}, out_pc, sb[0].pc);
            chk({tag, ".out_inst"}, 64'(out_inst), 64'(sb[0].inst));
            chk({tag, ".out_pred"}, 64'(out_pred), 64'(sb[0].pred));
        end else begin
            chk({tag, ".out_pc"}, out_pc, 64'h0);
            chk({tag, ".out_inst"}, 64'(out_inst), 64'(NOP));
            chk({tag, ".out_pred"}, 64'(out_pred), 64'h0);
        end
    endtask

    // One cycle: drive just after a rising edge, check mid-cycle, then advance the model.
    task automatic cyc(input string tag, input logic v, input logic [63:0] pc,
                       input logic [31:0] inst, input logic rdy, input logic fl);
        ent_t e;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        in_pred   = pc[2];
        out_ready = rdy;
        flush     = fl;
        #4;
        check_model(tag);
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            logic can_push;
            can_push = v && (sb.size() != DEPTH);
            if (rdy && sb.size() != 0) void'(sb.pop_front());
            if (can_push) begin
                e.pc   = pc;
                e.inst = inst;
                e.pred = pc[2];
                sb.push_back(e);
            end
        end
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [63:0] pc);
        return pc[31:0] ^ 32'hA5000093;
    endfunction

    initial begin
        // Reset held: outputs already defined.
        #2;
        chk("rst.out_valid", 64'(out_valid), 64'h0);
        chk("rst.in_ready", 64'(in_ready), 64'h1);
        chk("rst.out_pc", out_pc, 64'h0);
        chk("rst.out_inst", 64'(out_inst), 64'(NOP));
        chk("rst.out_pred", 64'(out_pred), 64'h0);
        chk("rst.count", 64'(count), 64'h0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // Single push into empty queue, then visible one cycle later.
        cyc("single0", 1'b1, 64'h1000, 32'h00500093, 1'b0, 1'b0);
        chk("single.out_pc", out_pc, 64'h1000);
        chk("single.out_inst", 64'(out_inst), 64'h00500093);
        chk("single.count", 64'(count), 64'h1);
        cyc("single1", 1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        cyc("single2", 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

        // Fill while stalled, then offer 0x10 that must be refused.
        for (int i = 0; i < 4; i++) begin
            cyc("fill", 1'b1, 64'(i * 4), mk(64'(i * 4)), 1'b0, 1'b0);
        end
        chk("full.count", 64'(count), 64'h4);
        chk("full.in_ready", 64'(in_ready), 64'h0);
        for (int i = 0; i < 3; i++) begin
            cyc("stall", 1'b1, 64'h10, mk(64'h10), 1'b0, 1'b0);
            chk("stall.out_pc", out_pc, 64'h0);
        end
        // Full with out_ready=1 and in_valid=1: pop only, then push+pop.
        cyc("fullpop", 1'b1, 64'h10, mk(64'h10), 1'b1, 1'b0);
        chk("fullpop.count", 64'(count), 64'h3);
        chk("fullpop.out_pc", out_pc, 64'h4);
        cyc("pushpop", 1'b1, 64'h10, mk(64'h10), 1'b1, 1'b0);
        chk("pushpop.count", 64'(count), 64'h3);
        chk("pushpop.out_pc", out_pc, 64'h8);
        for (int i = 0; i < 4; i++) cyc("drain", 1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        chk("drain.out_valid", 64'(out_valid), 64'h0);

        // Steady stream at count=2 across pointer wraps.
        cyc("prime", 1'b1, 64'h0, mk(64'h0), 1'b0, 1'b0);
        cyc("prime", 1'b1, 64'h4, mk(64'h4), 1'b0, 1'b0);
        for (int i = 2; i < 10; i++) begin
            cyc("stream", 1'b1, 64'(i * 4), mk(64'(i * 4)), 1'b1, 1'b0);
            chk("stream.count", 64'(count), 64'h2);
            chk("stream.out_pc", out_pc, 64'((i - 1) * 4));
        end
        cyc("stream_tail", 1'b1, 64'h28, mk(64'h28), 1'b0, 1'b0);

        // count=3 then flush with simultaneous push and pop.
        chk("preflush.count", 64'(count), 64'h3);
        cyc("flush", 1'b1, 64'hDEAD, mk(64'hDEAD), 1'b1, 1'b1);
        chk("flush.count", 64'(count), 64'h0);
        chk("flush.out_valid", 64'(out_valid), 64'h0);
        chk("flush.in_ready", 64'(in_ready), 64'h1);
        cyc("postflush", 1'b1, 64'h2000, mk(64'h2000), 1'b0, 1'b0);
        chk("postflush.out_pc", out_pc, 64'h2000);
        chk("postflush.out_valid", 64'(out_valid), 64'h1);

        // Asynchronous reset mid-run at count=3.
        cyc("prerst", 1'b1, 64'h2004, mk(64'h2004), 1'b0, 1'b0);
        cyc("prerst", 1'b1, 64'h2008, mk(64'h2008), 1'b0, 1'b0);
        chk("prerst.count", 64'(count), 64'h3);
        in_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("arst.count", 64'(count), 64'h0);
        chk("arst.out_valid", 64'(out_valid), 64'h0);
        chk("arst.out_inst", 64'(out_inst), 64'(NOP));
        chk("arst.out_pc", out_pc, 64'h0);
        chk("arst.in_ready", 64'(in_ready), 64'h1);
        sb.delete();
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        cyc("afterrst", 1'b1, 64'h3000, mk(64'h3000), 1'b0, 1'b0);
        cyc("afterrst", 1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        cyc("afterrst", 1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifid_queue.md
Name: ifid_queue

Overview:
- Parametrised IF/ID pipeline register. It replaces the single-entry IF/ID latch with a DEPTH-entry in-order instruction queue.
- Fetch pushes {PC, instruction, predicted-taken} with a valid/ready handshake. Decode pops with a valid/ready handshake.
- A hazard stall is expressed as out_ready=0, and a branch redirect as flush.
- Sits between the fetch stage and the ID stage. It decouples fetch from decode stalls by up to DEPTH instructions.

Parameters:
- XLEN, 64, PC width.
- ILEN, 32, instruction width.
- DEPTH, 4, queue entries; power of two, >=2.
- NOP_INST, 32'h00000013, value driven on out_inst when empty (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush of all entries (branch/jump redirect).
- in_valid  input  1  fetch presents an entry.
- in_ready  output  1  queue can accept an entry this cycle.
- in_pc  input  XLEN  PC of the fetched instruction.
- in_inst  input  ILEN  fetched instruction.
- in_pred  input  1  fetch predicted-taken flag.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head; 0 = hazard stall.
- out_pc  output  XLEN  head PC.
- out_inst  output  ILEN  head instruction.
- out_pred  output  1  head predicted-taken flag.
- count  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- State:
  - storage array of DEPTH entries, each {pc, inst, pred};
  - wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - count register.
- Reset (reset=0, asynchronous, any time including mid-transfer): wr_ptr=0, rd_ptr=0, count=0. Storage is not reset.
- Values while reset is asserted and after reset: out_valid=0, in_ready=1, out_pc=0, out_inst=NOP_INST, out_pred=0, count=0.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on registered state. There is no combinational path from out_ready to in_ready.
- out_valid = (count != 0).
- Head outputs:
  - when out_valid=1, out_pc/out_inst/out_pred = storage[rd_ptr];
  - when out_valid=0, out_pc=0, out_inst=NOP_INST, out_pred=0.
- Latency: an entry pushed at edge N is visible on out_* after edge N. There is no same-cycle bypass; an empty queue never forwards in_* combinationally.
- Push at the clock edge: storage[wr_ptr] <= {in_pc, in_inst, in_pred}; wr_ptr <= wr_ptr+1.
- Pop at the clock edge: rd_ptr <= rd_ptr+1.
- Count update:
  - push only: +1;
  - pop only: -1;
  - push and pop together: unchanged. This is legal at any count 1..DEPTH-1. At count=DEPTH, push is impossible because in_ready=0.
- in_valid while full: not accepted. Fetch must hold its data. The queue ignores it and state is unchanged.
- out_ready while empty: no effect.
- Stall (out_ready=0): the head entry and out_* hold stable every cycle. Pushes continue until full.
- Flush (flush=1 at an edge):
  - highest priority over push and pop;
  - wr_ptr=0, rd_ptr=0, count=0;
  - a push or pop in the same cycle is discarded;
  - out_valid=0 after the edge;
  - in_ready is unaffected during the flush cycle and is 1 after it.
- Pointer wrap: DEPTH-1 -> 0. Ordering is strictly FIFO across the wrap.
- No X on outputs after reset. Storage contents are never visible while out_valid=0.

Test Plan:
- Assert reset=0 mid-run with count=3.
  -> Immediately, without waiting for a clock edge: count=0, out_valid=0, out_inst=32'h00000013, out_pc=0, in_ready=1.
- Single push of pc=64'h1000, inst=32'h00500093, pred=0 into an empty queue.
  -> Same cycle: out_valid=0.
  -> Next cycle: out_valid=1, out_pc=64'h1000, out_inst=32'h00500093, count=1.
- DEPTH=4 with out_ready=0: push pc 0x0,0x4,0x8,0xC, then attempt pc 0x10.
  -> count=4 and in_ready=0.
  -> 0x10 is not accepted and out_pc stays 0x0 on every stalled cycle.
  -> Release out_ready: output sequence is 0x0,0x4,0x8,0xC.
- Continuous push and pop, count held at 2, for 10 cycles (pc 0x0..0x24).
  -> count stays 2.
  -> Popped PCs appear strictly in order across two pointer wraps.
- count=3 with flush=1, in_valid=1 and out_ready=1 in the same cycle.
  -> Next cycle: count=0, out_valid=0, and the flushed-cycle push is absent.
  -> The following push appears with 1-cycle latency.
- Full queue with out_ready=1 and in_valid=1.
  -> Cycle 1: only a pop occurs (in_ready was 0); count goes 4 -> 3.
  -> Cycle 2: push and pop together; count stays 3.
